// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, constants and counter helper for the branch predictor
// Purpose: 2-bit direction counter encoding, BTB entry layout, reset values,
//          and the saturating counter update used by the training path.
// Ports: none (package).
package bp_pkg;

  // Tag is stored at its widest possible size (pc[31:2]). For a given
  // ENTRIES only pc[31:IDX_W+2] is kept, zero-extended, so one struct
  // serves every legal table size.
  localparam int TAG_W = 30;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    ctr_t             ctr;
  } btb_entry_t;

  localparam int ENTRY_W = $bits(btb_entry_t);

  localparam btb_entry_t ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    CTR_RESET
  };

  // Saturating step: ST stays ST on taken, SNT stays SNT on not-taken.
  function automatic ctr_t sat_update(ctr_t c, logic taken);
    ctr_t n;
    n = c;
    case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = CTR_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bp_table.sv
// rtl/bp_table.sv - BTB storage: register array, two combinational reads, one synchronous write
// Purpose: holds ENTRIES btb_entry_t records; clears every entry on rst.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rd_idx / rd_entry  fetch-side lookup (combinational)
//   up_idx / up_entry  training-side lookup (combinational)
//   wr_en, wr_idx, wr_entry  synchronous write; ignored while rst is high
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [ENTRY_W-1:0] rd_entry,
  input  logic [IDX_W-1:0]   up_idx,
  output logic [ENTRY_W-1:0] up_entry,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [ENTRY_W-1:0] wr_entry
);

  btb_entry_t mem [ENTRIES];

  // Reads see the registered contents only: a write on this edge becomes
  // visible on the next cycle, with no bypass.
  assign rd_entry = mem[rd_idx];
  assign up_entry = mem[up_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= ENTRY_RESET;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= btb_entry_t'(wr_entry);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters (top)
// Purpose: predicts next PC for the fetch PC, trains on EX-stage branch
//          resolutions, and raises a same-cycle mispredict/redirect.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   f_pc -> pred_taken, pred_target   combinational fetch prediction
//   upd_valid, upd_pc, upd_taken, upd_is_jmp, upd_actual_pc,
//   upd_pred_taken, upd_pred_target  resolution from EX
//   mispredict, redirect_pc       combinational flush/redirect
//   stat_branches, stat_mispredicts   present only when BP_STATS_EN is defined
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_is_jmp,
  input  logic [31:0] upd_actual_pc,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] f_tag;
  logic [TAG_W-1:0] u_tag;
  btb_entry_t       rd_entry;
  btb_entry_t       up_entry;
  btb_entry_t       wr_entry;
  logic             wr_en;
  logic             f_hit;
  logic             u_hit;
  logic             unused_pc_bits;

  // pc[1:0] never participates in index or tag.
  assign unused_pc_bits = ^upd_pc[1:0];

  assign rd_idx = f_pc[IDX_W+1:2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign f_tag  = f_pc[31:2] >> IDX_W;
  assign u_tag  = upd_pc[31:2] >> IDX_W;

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_entry (rd_entry),
    .up_idx   (up_idx),
    .up_entry (up_entry),
    .wr_en    (wr_en),
    .wr_idx   (up_idx),
    .wr_entry (wr_entry)
  );

  // Fetch lookup. Gating with rst keeps the first reset cycle (table not
  // yet cleared) from predicting out of stale contents.
  assign f_hit       = rd_entry.valid && (rd_entry.tag == f_tag);
  assign pred_taken  = !rst && f_hit && rd_entry.ctr[1];
  assign pred_target = pred_taken ? rd_entry.target : f_pc + 32'd4;

  // Target mismatch only matters when the branch was actually taken; a
  // not-taken branch that was predicted not-taken is always correct.
  assign mispredict  = upd_valid && !rst &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_actual_pc != upd_pred_target)));
  assign redirect_pc = upd_actual_pc;

  assign u_hit = up_entry.valid && (up_entry.tag == u_tag);

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = up_entry;
    if (upd_valid && !rst) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (upd_is_jmp) begin
          wr_entry.ctr    = ST;
          wr_entry.target = upd_actual_pc;
        end else begin
          wr_entry.ctr = sat_update(up_entry.ctr, upd_taken);
          if (upd_taken) begin
            wr_entry.target = upd_actual_pc;
          end
        end
      end else if (upd_taken) begin
        // Allocate on a taken miss, evicting whatever aliases this index.
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = u_tag;
        wr_entry.target = upd_actual_pc;
        wr_entry.ctr    = upd_is_jmp ? ST : WT;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_is_jmp;
  logic [31:0] upd_actual_pc;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: per-slot valid/tag/target and an integer counter 0..3.
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int unsigned m_br = 0;
  int unsigned m_mp = 0;

  branch_predictor #(
    .ENTRIES (ENTRIES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .f_pc            (f_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_is_jmp      (upd_is_jmp),
    .upd_actual_pc   (upd_actual_pc),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_ctr[i]    = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i;
    i  = idx_of(pc);
    t  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    tg = t ? m_target[i] : pc + 32'd4;
  endtask

  task automatic model_train();
    int i;
    bit hit;
    i   = idx_of(upd_pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
    if (hit) begin
      if (upd_is_jmp) begin
        m_ctr[i]    = 3;
        m_target[i] = upd_actual_pc;
      end else if (upd_taken) begin
        m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_target[i] = upd_actual_pc;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (upd_taken) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(upd_pc);
      m_target[i] = upd_actual_pc;
      m_ctr[i]    = upd_is_jmp ? 3 : 2;
    end
  endtask

  // Called at posedge+1 with inputs already applied: checks every output
  // against the model, then crosses one clock edge and trains the model.
  task automatic step();
    logic        e_pt;
    logic [31:0] e_tg;
    logic        e_mp;
    #2;
    model_predict(f_pc, e_pt, e_tg);
    if (rst) begin
      e_pt = 1'b0;
      e_tg = f_pc + 32'd4;
    end
    e_mp = upd_valid && !rst &&
           ((upd_taken != upd_pred_taken) ||
            (upd_taken && (upd_actual_pc != upd_pred_target)));
    chk("pred_taken", 32'(pred_taken), 32'(e_pt));
    chk("pred_target", pred_target, e_tg);
    chk("mispredict", 32'(mispredict), 32'(e_mp));
    if (upd_valid) chk("redirect_pc", redirect_pc, upd_actual_pc);
`ifdef BP_STATS_EN
    chk("stat_branches", stat_branches, m_br);
    chk("stat_mispredicts", stat_mispredicts, m_mp);
`endif
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (upd_valid) begin
      m_br++;
      if (e_mp) m_mp++;
      model_train();
    end
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic j,
                     input logic [31:0] act, input logic pt, input logic [31:0] ptg);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = t;
    upd_is_jmp      = j;
    upd_actual_pc   = act;
    upd_pred_taken  = pt;
    upd_pred_target = ptg;
  endtask

  task automatic idle();
    upd_valid       = 1'b0;
    upd_pc          = $urandom;
    upd_taken       = 1'($urandom);
    upd_is_jmp      = 1'($urandom);
    upd_actual_pc   = $urandom;
    upd_pred_taken  = 1'($urandom);
    upd_pred_target = $urandom;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'h1000 + (32'($urandom_range(0, 2)) << (IDX_W + 2))
                 + (32'($urandom_range(0, ENTRIES - 1)) << 2)
                 + 32'($urandom_range(0, 3));
    return p;
  endfunction

  initial begin
    model_reset();
    rst  = 1'b1;
    f_pc = 32'h100;
    idle();
    @(posedge clk);
    #1;
    step();
    // Training during reset must be dropped.
    upd(32'h300, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    #1;
    chk("mispredict_in_reset", 32'(mispredict), 32'd0);
    step();
    rst = 1'b0;
    idle();
    f_pc = 32'h100;
    #1;
    chk("post_reset_taken", 32'(pred_taken), 32'd0);
    chk("post_reset_target", pred_target, 32'h104);
    step();
    f_pc = 32'h300;
    step();

    // First taken resolution allocates as WT.
    f_pc = 32'h100;
    upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h104);
    #1;
    chk("first_mispredict", 32'(mispredict), 32'd1);
    chk("first_redirect", redirect_pc, 32'h80);
    step();
    idle();
    #1;
    chk("alloc_taken", 32'(pred_taken), 32'd1);
    chk("alloc_target", pred_target, 32'h80);
    step();

    // WT -> WNT -> SNT -> SNT, then one taken lands on WNT (still not taken).
    upd(32'h100, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
    step();
    idle();
    #1;
    chk("wnt_pred", 32'(pred_taken), 32'd0);
    step();
    upd(32'h100, 1'b0, 1'b0, 32'h104, 1'b0, 32'h104);
    step();
    upd(32'h100, 1'b0, 1'b0, 32'h104, 1'b0, 32'h104);
    step();
    upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h104);
    step();
    idle();
    #1;
    chk("snt_saturated", 32'(pred_taken), 32'd0);
    step();

    // Jump allocation, then an alias at the same index evicts it.
    upd(32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204);
    step();
    idle();
    f_pc = 32'h200;
    #1;
    chk("jal_target", pred_target, 32'h400);
    step();
    upd(32'h240, 1'b1, 1'b0, 32'h10, 1'b0, 32'h244);
    step();
    idle();
    #1;
    chk("evicted_target", pred_target, 32'h204);
    step();
    f_pc = 32'h240;
    step();

    // Wrong target with right direction still mispredicts.
    f_pc = 32'h100;
    upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h84);
    #1;
    chk("target_mispredict", 32'(mispredict), 32'd1);
    step();
    upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    chk("correct_predict", 32'(mispredict), 32'd0);
    step();

    idle();
    f_pc = 32'hFFFF_FFFC;
    #1;
    chk("wrap_target", pred_target, 32'h0);
    step();

`ifdef BP_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    upd(32'h500, 1'b1, 1'b0, 32'h600, 1'b0, 32'h504);
    step();
    upd(32'h500, 1'b0, 1'b0, 32'h504, 1'b1, 32'h600);
    step();
    upd(32'h700, 1'b0, 1'b0, 32'h704, 1'b0, 32'h704);
    step();
    upd(32'h500, 1'b0, 1'b0, 32'h504, 1'b0, 32'h504);
    step();
    upd(32'h800, 1'b1, 1'b1, 32'h900, 1'b1, 32'h900);
    step();
    idle();
    #1;
    chk("stat_branches_5", stat_branches, 32'd5);
    chk("stat_mispredicts_2", stat_mispredicts, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("stat_branches_rst", stat_branches, 32'd0);
    chk("stat_mispredicts_rst", stat_mispredicts, 32'd0);
    step();
`endif

    // Randomized training against the model.
    for (int n = 0; n < 600; n++) begin
      logic        mt;
      logic [31:0] mtg;
      rst  = ($urandom_range(0, 63) == 0);
      f_pc = rand_pc();
      if ($urandom_range(0, 1) == 1) begin
        upd_valid  = 1'b1;
        upd_pc     = rand_pc();
        upd_is_jmp = ($urandom_range(0, 3) == 0);
        upd_taken  = upd_is_jmp ? 1'b1 : 1'($urandom);
        upd_actual_pc = upd_taken ? ($urandom & 32'hFFFF_FFFC) : upd_pc + 32'd4;
        model_predict(upd_pc, mt, mtg);
        if ($urandom_range(0, 1) == 1) begin
          upd_pred_taken  = mt;
          upd_pred_target = mtg;
        end else begin
          upd_pred_taken  = 1'($urandom);
          upd_pred_target = $urandom_range(0, 1) == 1 ? upd_actual_pc : $urandom;
        end
      end else begin
        idle();
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
